// File: rtl/mmio_coin_hub_if.sv
// ---------------------------------------------------------------------------
// mmio_coin_hub_if
// Processor data-memory port as seen by the coin-machine IO hub.
//   addr  : 12-bit word address (master -> hub)
//   wren  : write enable       (master -> hub)
//   wdata : write data         (master -> hub)
//   rdata : read data, combinational from addr (hub -> master)
//   hit   : addr falls inside the hub's 32-word window (hub -> master)
// ---------------------------------------------------------------------------
interface mmio_coin_hub_if;
    logic [11:0] addr;
    logic        wren;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;

    modport master (output addr, output wren, output wdata, input rdata, input hit);
    modport slave  (input addr, input wren, input wdata, output rdata, output hit);
endinterface

// File: rtl/mmio_coin_hub.sv
// ---------------------------------------------------------------------------
// mmio_coin_hub
// Memory-mapped IO hub for the coin machine: synchronises and debounces the
// beam-break sensors, counts coin events per channel, keeps sticky pending
// flags with a maskable interrupt, and holds the output registers that feed
// the seven-segment / LED logic.
//
// Ports:
//   i_clock    : system clock
//   i_reset    : asynchronous, active-low reset
//   i_beam_in  : raw sensor inputs, low = beam broken
//   bus        : processor data port (mmio_coin_hub_if.slave)
//   o_out_regs : output registers, register k at [32k+31:32k]
//   o_irq      : registered OR of (pending & mask)
//
// Word map (offset from BASE_ADDR):
//   0..NUM_CH-1   debounced broken level (bit 0), read only
//   8..8+NUM_CH-1 event counter, any write clears
//   16            pending flags, write-1-to-clear
//   17            interrupt mask
//   18            running coin total (MMIO_COIN_TOTAL_EN only, else 0)
//   24..24+NUM_OUT-1 output registers
//
// Optional feature macro: MMIO_COIN_TOTAL_EN (adds CH_WEIGHTS and the
// weighted, saturating running total at offset 18).
// ---------------------------------------------------------------------------
module mmio_coin_hub #(
    parameter int          NUM_CH          = 4,
    parameter int          NUM_OUT         = 4,
    parameter int          CNT_W           = 16,
    parameter int          DEBOUNCE_CYCLES = 30000,
    parameter logic [11:0] BASE_ADDR       = 12'd0
`ifdef MMIO_COIN_TOTAL_EN
    ,
    parameter logic [NUM_CH*8-1:0] CH_WEIGHTS = {8'd25, 8'd10, 8'd5, 8'd1}
`endif
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [NUM_CH-1:0]      i_beam_in,
    mmio_coin_hub_if.slave         bus,
    output logic [NUM_OUT*32-1:0]  o_out_regs,
    output logic                   o_irq
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    // r_db holds the debounced line level: 1 = not broken
    logic [NUM_CH-1:0]  r_sync1;
    logic [NUM_CH-1:0]  r_sync2;
    logic [NUM_CH-1:0]  r_db;
    logic [DB_W-1:0]    r_db_cnt [NUM_CH];
    logic [CNT_W-1:0]   r_cnt    [NUM_CH];
    logic [NUM_CH-1:0]  r_pend;
    logic [NUM_CH-1:0]  r_mask;
    logic [NUM_OUT*32-1:0] r_out;
    logic               r_irq;

    logic [11:0]        w_off;
    logic [4:0]         w_idx;
    logic               w_wr;
    logic [NUM_CH-1:0]  w_flip;
    logic [NUM_CH-1:0]  w_evt;
    logic [NUM_CH-1:0]  w_cnt_clr;
    logic [NUM_CH-1:0]  w_pend_next;
    logic [NUM_CH-1:0]  w_mask_next;
    logic [31:0]        w_rdata;

    assign w_off   = bus.addr - BASE_ADDR;
    assign bus.hit = (bus.addr >= BASE_ADDR) && (w_off[11:5] == 7'd0);
    assign w_idx   = w_off[4:0];
    assign w_wr    = bus.wren && bus.hit;

    // A flip happens on the edge where the line has differed for
    // DEBOUNCE_CYCLES consecutive samples; an event is a flip to broken.
    always_comb begin
        w_flip    = '0;
        w_evt     = '0;
        w_cnt_clr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_flip[i]    = (r_sync2[i] != r_db[i]) &&
                           (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1));
            w_evt[i]     = w_flip[i] && r_db[i];
            w_cnt_clr[i] = w_wr && (w_idx == 5'(8 + i));
        end
    end

    // Events win over a same-cycle W1C so no coin is lost
    assign w_pend_next = (r_pend & ~((w_wr && w_idx == 5'd16) ? bus.wdata[NUM_CH-1:0]
                                                               : {NUM_CH{1'b0}}))
                         | w_evt;
    assign w_mask_next = (w_wr && w_idx == 5'd17) ? bus.wdata[NUM_CH-1:0] : r_mask;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_db    <= '1;
            for (int i = 0; i < NUM_CH; i++) begin
                r_db_cnt[i] <= '0;
                r_cnt[i]    <= '0;
            end
            r_pend  <= '0;
            r_mask  <= '0;
            r_out   <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_sync1 <= i_beam_in;
            r_sync2 <= r_sync1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (w_flip[i]) begin
                    r_db[i]     <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end

                if (w_cnt_clr[i]) begin
                    r_cnt[i] <= w_evt[i] ? CNT_W'(1) : '0;
                end else if (w_evt[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
            r_pend <= w_pend_next;
            r_mask <= w_mask_next;
            r_irq  <= |(w_pend_next & w_mask_next);
            for (int k = 0; k < NUM_OUT; k++) begin
                if (w_wr && (w_idx == 5'(24 + k))) begin
                    r_out[k*32 +: 32] <= bus.wdata;
                end
            end
        end
    end

`ifdef MMIO_COIN_TOTAL_EN
    logic [31:0] r_total;
    logic [31:0] w_add;
    logic [32:0] w_sum;
    logic        w_tot_clr;

    always_comb begin
        w_add = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_evt[i]) begin
                w_add = w_add + 32'(CH_WEIGHTS[i*8 +: 8]);
            end
        end
    end

    assign w_sum     = {1'b0, r_total} + {1'b0, w_add};
    assign w_tot_clr = w_wr && (w_idx == 5'd18);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_total <= '0;
        end else if (w_tot_clr) begin
            r_total <= w_add;
        end else if (w_sum[32]) begin
            r_total <= '1;
        end else begin
            r_total <= w_sum[31:0];
        end
    end
`endif

    always_comb begin
        w_rdata = '0;
        if (bus.hit) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_idx == 5'(i)) begin
                    w_rdata[0] = ~r_db[i];
                end
                if (w_idx == 5'(8 + i)) begin
                    w_rdata[CNT_W-1:0] = r_cnt[i];
                end
            end
            if (w_idx == 5'd16) begin
                w_rdata[NUM_CH-1:0] = r_pend;
            end
            if (w_idx == 5'd17) begin
                w_rdata[NUM_CH-1:0] = r_mask;
            end
`ifdef MMIO_COIN_TOTAL_EN
            if (w_idx == 5'd18) begin
                w_rdata = r_total;
            end
`endif
            for (int k = 0; k < NUM_OUT; k++) begin
                if (w_idx == 5'(24 + k)) begin
                    w_rdata = r_out[k*32 +: 32];
                end
            end
        end
    end

    assign bus.rdata  = w_rdata;
    assign o_out_regs = r_out;
    assign o_irq      = r_irq;

endmodule

// File: tb/tb_mmio_coin_hub.sv
module tb_mmio_coin_hub;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   beam = 4'b0000;
    logic [127:0] outr;
    logic         irq;
    int           total = 0;
    int           bad = 0;

    mmio_coin_hub_if bus();

    mmio_coin_hub #(
        .NUM_CH(4), .NUM_OUT(4), .CNT_W(2), .DEBOUNCE_CYCLES(4), .BASE_ADDR(12'd0)
    ) dut (
        .i_clock(clk), .i_reset(rst_n), .i_beam_in(beam), .bus(bus),
        .o_out_regs(outr), .o_irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        bus.addr = a;
        bus.wren = 1'b0;
        #1;
        chk(tag, {96'd0, bus.rdata}, {96'd0, exp});
    endtask

    task automatic tick(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.wren  = 1'b1;
        @(posedge clk);
        #1;
        bus.wren  = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] m);
        beam = beam & ~m;
        tick(8);
        beam = beam | m;
        tick(8);
    endtask

    initial begin
        bus.addr  = 12'd0;
        bus.wren  = 1'b0;
        bus.wdata = 32'd0;

        // reset state
        tick(2);
        for (int a = 0; a < 32; a++) chk_rd("reset_rd", 12'(a), 32'd0);
        chk("reset_irq", {127'd0, irq}, 128'd0);
        chk("reset_out", outr, 128'd0);

        // release with all beams broken: debounced level flips on 6th edge
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(5);
        chk_rd("db_before_6", 12'd0, 32'd0);
        tick(1);
        chk_rd("db_after_6", 12'd0, 32'd1);
        chk_rd("pend_after_rel", 12'd16, 32'hF);
        chk_rd("cnt0_after_rel", 12'd8, 32'd1);

        beam = 4'hF;
        tick(8);
        wr(12'd8, 32'd0); wr(12'd9, 32'd0); wr(12'd10, 32'd0); wr(12'd11, 32'd0);
        wr(12'd16, 32'hF);
        chk_rd("pend_cleared", 12'd16, 32'd0);
        chk_rd("cnt2_cleared", 12'd10, 32'd0);

        // 3-cycle glitch ignored
        beam = 4'b1011;
        tick(3);
        beam = 4'hF;
        tick(8);
        chk_rd("glitch_cnt2", 12'd10, 32'd0);
        chk_rd("glitch_db2", 12'd2, 32'd0);

        // sustained break -> one event
        beam = 4'b1011;
        tick(10);
        chk_rd("evt_db2", 12'd2, 32'd1);
        chk_rd("evt_cnt2", 12'd10, 32'd1);
        chk_rd("evt_pend", 12'd16, 32'h4);
        chk("irq_masked", {127'd0, irq}, 128'd0);
        wr(12'd17, 32'h4);
        chk("irq_unmasked", {127'd0, irq}, 128'd1);

        // W1C collides with second channel-2 event
        beam = 4'hF;
        tick(8);
        wr(12'd16, 32'h4);
        chk_rd("w1c_pend", 12'd16, 32'd0);
        chk("w1c_irq", {127'd0, irq}, 128'd0);
        beam = 4'b1011;
        tick(5);
        wr(12'd16, 32'h4);
        chk_rd("coll_pend", 12'd16, 32'h4);
        chk_rd("coll_cnt2", 12'd10, 32'd2);
        chk("coll_irq", {127'd0, irq}, 128'd1);

        // saturation on channel 0 (2-bit counter)
        beam = 4'hF;
        tick(8);
        for (int e = 0; e < 5; e++) pulse(4'b0001);
        chk_rd("sat_cnt0", 12'd8, 32'd3);
        chk_rd("sat_pend", 12'd16, 32'h5);

        // counter clear in the event cycle leaves 1
        beam = 4'b1110;
        tick(5);
        wr(12'd8, 32'h1234);
        chk_rd("clr_coll_cnt0", 12'd8, 32'd1);
        beam = 4'hF;
        tick(8);

        // output registers
        wr(12'd25, 32'h0000_0007);
        chk("out_reg1", outr, {64'd0, 32'd7, 32'd0});
        chk_rd("out_rd25", 12'd25, 32'd7);
        wr(12'd40, 32'hDEAD_BEEF);
        chk("miss_hit", {127'd0, bus.hit}, 128'd0);
        chk_rd("miss_rdata", 12'd40, 32'd0);
        chk("miss_out", outr, {64'd0, 32'd7, 32'd0});
        chk_rd("miss_cnt0", 12'd8, 32'd1);
        wr(12'd24, 32'hA5A5_0001);
        wr(12'd27, 32'h8000_0000);
        chk("out_all", outr, {32'h8000_0000, 32'd0, 32'd7, 32'hA5A5_0001});
        chk_rd("unused_12", 12'd12, 32'd0);
        chk_rd("unused_28", 12'd28, 32'd0);
        chk_rd("mask_rd", 12'd17, 32'h4);
        chk_rd("db_idle3", 12'd3, 32'd0);

`ifdef MMIO_COIN_TOTAL_EN
        wr(12'd18, 32'd0);
        chk_rd("tot_clr", 12'd18, 32'd0);
        pulse(4'b1000);
        pulse(4'b0010);
        pulse(4'b0001);
        chk_rd("tot_3_1_0", 12'd18, 32'd25 + 32'd5 + 32'd1);
        pulse(4'b1100);
        chk_rd("tot_simul", 12'd18, 32'd25 + 32'd5 + 32'd1 + 32'd35);
`else
        wr(12'd18, 32'hFFFF_FFFF);
        chk_rd("tot_absent", 12'd18, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
